dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the load/store side of the single-cycle CPU datapath.
- Accepts load/store requests carrying the decoder's store byte-enable pattern and the load funct3 code.
- Steers byte lanes by address, applies sign/zero extension on loads, and returns a response after a programmable number of wait cycles over a valid/ready handshake.
- Internal storage is a word-organised RAM.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, min 4.
- WAIT_CYCLES, 1, extra cycles between accept and response; range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address.
- req_dwe  input  4  store byte-enable, unshifted: 0001=SB, 0011=SH, 1111=SW, 0000=load.
- req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_wdata  input  32  store data, low-aligned (SB uses [7:0], SH uses [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  request faulted.

Behaviour:
- Reset, asynchronous: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Handshake when req_valid&&req_ready.
  - Register addr, dwe, funct3, wdata.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 on accept and decrements each cycle. At 0, the RAM access is performed and the state goes to RESP.
- RESP: rsp_valid=1 with rdata/err stable until rsp_valid&&rsp_ready. On that edge go to IDLE; req_ready returns to 1 the following cycle, so there are no back-to-back accepts.
- Latency: the response is visible WAIT_CYCLES+1 cycles after the accept edge. Max throughput is one request per WAIT_CYCLES+2 cycles.
- Store path:
  - Effective byte mask = req_dwe << addr[1:0].
  - Write data is replicated: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - Only masked bytes are written, at word index addr[log2(DEPTH)+1:2].
  - The write happens once, on the WAIT→RESP edge, or IDLE→RESP when WAIT_CYCLES=0.
- Load path:
  - The selected byte/halfword is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Errors: rsp_err=1, no RAM write, rsp_rdata=0 when any of the following holds:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - req_dwe not in {0000,0001,0011,1111};
  - load funct3 in {011,110,111};
  - addr ≥ 4*DEPTH.
- Store with req_funct3 nonzero: funct3 is ignored; only dwe matters.
- req_valid while not ready: ignored; the requester must hold it.
- rsp_ready asserted with rsp_valid=0: no effect.
- Reset mid-operation (WAIT or RESP): request dropped, outputs return to reset values. Any write already committed persists; otherwise none occurs.
- Request fields are sampled only at accept; later changes have no effect.

Test Plan:
- WAIT_CYCLES=1: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each accept.
- After the above: SB addr 0x13 wdata 0x000000AA, then LW 0x10 → 0xAAADBEEF; LB 0x13 → 0xFFFFFFAA; LBU 0x13 → 0x000000AA.
- SH addr 0x12 wdata 0x00008001, then LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001; LW 0x10 → 0x8001BEEF.
- Misaligned LW 0x11 and SH 0x13 → rsp_err=1, rsp_rdata=0; subsequent LW 0x10 unchanged (0x8001BEEF).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid/rdata stable, req_ready=0; release → IDLE next cycle. WAIT_CYCLES=0 build: response 1 cycle after accept.
- Assert rst during WAIT of a SW to 0x20 (WAIT_CYCLES=3) → outputs reset immediately; LW 0x20 after release returns the prior contents, not the store data.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the load/store side of the CPU datapath.
//   Accepts one request at a time over a valid/ready handshake, waits
//   WAIT_CYCLES cycles, performs the RAM access, then holds the response
//   until the consumer takes it.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_addr            byte address
//   req_dwe             store byte-enable, unshifted (0000 = load)
//   req_funct3          load type (LB/LH/LW/LBU/LHU), ignored for stores
//   req_wdata           store data, low-aligned
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           load result, 0 for stores and faulted requests
//   rsp_err             request faulted
//
// States:
//   IDLE | ready for a request
//   WAIT | counting down the programmed wait cycles
//   RESP | response held until accepted
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_dwe,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  dwe_q;
    logic [2:0]  f3_q;

    logic [31:0] mem [DEPTH];

    logic        accept, do_access;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_dwe;
    logic [2:0]  a_f3;
    logic        is_store, acc_err;
    logic [AW-1:0] idx;
    logic [31:0] rd_word, rd_shift, load_data, wdata_rep;
    logic [3:0]  wmask;

    assign accept = (state == S_IDLE) && req_valid;

    // With no wait cycles the access happens on the accept edge itself, so it
    // must see the live request fields instead of the (not yet loaded) registers.
    assign a_addr  = (state == S_IDLE) ? req_addr   : addr_q;
    assign a_wdata = (state == S_IDLE) ? req_wdata  : wdata_q;
    assign a_dwe   = (state == S_IDLE) ? req_dwe    : dwe_q;
    assign a_f3    = (state == S_IDLE) ? req_funct3 : f3_q;

    // Gated by rst so nothing is written while reset is held across a clock edge.
    assign do_access = !rst && ((accept && (WAIT_CYCLES == 0)) ||
                                ((state == S_WAIT) && (cnt == 4'd0)));

    always_comb begin
        is_store  = (a_dwe != 4'b0000);
        acc_err   = 1'b0;
        idx       = a_addr[AW+1:2];
        rd_word   = mem[idx];
        rd_shift  = rd_word >> {a_addr[1:0], 3'b000};
        load_data = 32'd0;
        wdata_rep = a_wdata;
        wmask     = a_dwe << a_addr[1:0];

        if (is_store) begin
            case (a_dwe)
                4'b0001: wdata_rep = {4{a_wdata[7:0]}};
                4'b0011: begin
                    wdata_rep = {2{a_wdata[15:0]}};
                    acc_err   = a_addr[0];
                end
                4'b1111: acc_err = |a_addr[1:0];
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (a_f3)
                3'b000: load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
                3'b100: load_data = {24'd0, rd_shift[7:0]};
                3'b001: begin
                    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
                    acc_err   = a_addr[0];
                end
                3'b101: begin
                    load_data = {16'd0, rd_shift[15:0]};
                    acc_err   = a_addr[0];
                end
                3'b010: begin
                    load_data = rd_word;
                    acc_err   = |a_addr[1:0];
                end
                default: acc_err = 1'b1;
            endcase
        end

        if ({1'b0, a_addr} >= MEM_BYTES) acc_err = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            dwe_q     <= 4'd0;
            f3_q      <= 3'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                dwe_q   <= req_dwe;
                f3_q    <= req_funct3;
                cnt     <= WAIT_INIT;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_rdata <= (acc_err || is_store) ? 32'd0 : load_data;
                rsp_err   <= acc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && is_store && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr [3];
    logic [3:0]  req_dwe [3];
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d0: WAIT_CYCLES=1, d1: WAIT_CYCLES=0, d2: WAIT_CYCLES=3; all 64 words
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(1)) u_d0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_dwe(req_dwe[0]), .req_funct3(req_funct3[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_d1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_dwe(req_dwe[1]), .req_funct3(req_funct3[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(3)) u_d2 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .req_dwe(req_dwe[2]), .req_funct3(req_funct3[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    typedef struct {
        logic [3:0]  dwe;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on instance d, scramble the inputs after accept,
    // wait for the response, capture it and take it with rsp_ready.
    task automatic do_req(input int d, input logic [3:0] dwe, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_valid[d] = 1'b1; req_dwe[d] = dwe; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_addr[d] = 32'hFFFF_FFFF; req_dwe[d] = 4'b1111;
        req_funct3[d] = 3'b111; req_wdata[d] = $urandom;
        n = 0;
        while (!rsp_valid[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        lat = n + 1;
        rdata = rsp_rdata[d];
        err = rsp_err[d];
        if (!rsp_valid[d]) begin
            errors++;
            $display("FAIL timeout on instance %0d: no rsp_valid, required 1", d);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    string       nm;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
            req_addr[d] = 32'd0; req_dwe[d] = 4'd0; req_funct3[d] = 3'd0; req_wdata[d] = 32'd0;
        end

        //            dwe      f3      addr          wdata          rdata          err
        tbl[0]  = '{4'b1111, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{4'b0000, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{4'b0001, 3'b000, 32'h13,  32'h000000AA, 32'h0,        1'b0};
        tbl[3]  = '{4'b0000, 3'b010, 32'h10,  32'h0,        32'hAAADBEEF, 1'b0};
        tbl[4]  = '{4'b0000, 3'b000, 32'h13,  32'h0,        32'hFFFFFFAA, 1'b0};
        tbl[5]  = '{4'b0000, 3'b100, 32'h13,  32'h0,        32'h000000AA, 1'b0};
        tbl[6]  = '{4'b0011, 3'b111, 32'h12,  32'h00008001, 32'h0,        1'b0};
        tbl[7]  = '{4'b0000, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 1'b0};
        tbl[8]  = '{4'b0000, 3'b101, 32'h12,  32'h0,        32'h00008001, 1'b0};
        tbl[9]  = '{4'b0000, 3'b010, 32'h10,  32'h0,        32'h8001BEEF, 1'b0};
        tbl[10] = '{4'b0000, 3'b010, 32'h11,  32'h0,        32'h0,        1'b1};
        tbl[11] = '{4'b0011, 3'b000, 32'h13,  32'h00001234, 32'h0,        1'b1};
        tbl[12] = '{4'b0000, 3'b010, 32'h10,  32'h0,        32'h8001BEEF, 1'b0};
        tbl[13] = '{4'b0111, 3'b000, 32'h10,  32'h11111111, 32'h0,        1'b1};
        tbl[14] = '{4'b0000, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1};
        tbl[15] = '{4'b0000, 3'b000, 32'h11,  32'h0,        32'hFFFFFFBE, 1'b0};
        tbl[16] = '{4'b0000, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0};
        tbl[17] = '{4'b1111, 3'b000, 32'h00,  32'h11111111, 32'h0,        1'b0};
        tbl[18] = '{4'b1111, 3'b000, 32'h100, 32'h55555555, 32'h0,        1'b1};
        tbl[19] = '{4'b0000, 3'b010, 32'h00,  32'h0,        32'h11111111, 1'b0};
        tbl[20] = '{4'b1111, 3'b000, 32'hFC,  32'h12345678, 32'h0,        1'b0};
        tbl[21] = '{4'b0000, 3'b010, 32'hFC,  32'h0,        32'h12345678, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset req_ready d%0d", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset rsp_rdata d%0d", d), rsp_rdata[d], 32'd0);
            check($sformatf("reset rsp_err d%0d", d), 32'(rsp_err[d]), 32'd0);
            rst[d] = 1'b0;
        end
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            do_req(0, tbl[i].dwe, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
        end

        // Backpressure: LW 0x10, hold rsp_ready low 5 cycles while a stray
        // request is presented; it must be ignored.
        req_valid[0] = 1'b1; req_dwe[0] = 4'b0000; req_funct3[0] = 3'b010; req_addr[0] = 32'h10;
        @(posedge clk); #1;
        req_dwe[0] = 4'b1111; req_wdata[0] = 32'hBADBAD00;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            nm = $sformatf("bp cyc%0d", c);
            check({nm, " rsp_valid"}, 32'(rsp_valid[0]), 32'd1);
            check({nm, " rdata"}, rsp_rdata[0], 32'h8001BEEF);
            check({nm, " req_ready"}, 32'(req_ready[0]), 32'd0);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        check("bp release rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp release req_ready", 32'(req_ready[0]), 32'd1);
        do_req(0, 4'b0000, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check("after stray request LW 0x10", rd, 32'h8001BEEF);

        // Zero-wait build
        do_req(1, 4'b1111, 3'b010, 32'h8, 32'hCAFEF00D, rd, er, lat);
        check("w0 SW latency", 32'(lat), 32'd1);
        check("w0 SW err", 32'(er), 32'd0);
        do_req(1, 4'b0000, 3'b010, 32'h8, 32'h0, rd, er, lat);
        check("w0 LW latency", 32'(lat), 32'd1);
        check("w0 LW rdata", rd, 32'hCAFEF00D);
        do_req(1, 4'b0000, 3'b000, 32'h9, 32'h0, rd, er, lat);
        check("w0 LB rdata", rd, 32'hFFFFFFF0);

        // Three-wait build: reset during WAIT of a store
        do_req(2, 4'b1111, 3'b010, 32'h20, 32'h01020304, rd, er, lat);
        check("w3 SW latency", 32'(lat), 32'd4);
        do_req(2, 4'b0000, 3'b010, 32'h20, 32'h0, rd, er, lat);
        check("w3 LW rdata", rd, 32'h01020304);
        req_valid[2] = 1'b1; req_dwe[2] = 4'b1111; req_funct3[2] = 3'b010;
        req_addr[2] = 32'h20; req_wdata[2] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        check("w3 in WAIT req_ready", 32'(req_ready[2]), 32'd0);
        rst[2] = 1'b1;
        #1;
        check("mid-reset req_ready", 32'(req_ready[2]), 32'd1);
        check("mid-reset rsp_valid", 32'(rsp_valid[2]), 32'd0);
        check("mid-reset rsp_rdata", rsp_rdata[2], 32'd0);
        check("mid-reset rsp_err", 32'(rsp_err[2]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        @(posedge clk); #1;
        do_req(2, 4'b0000, 3'b010, 32'h20, 32'h0, rd, er, lat);
        check("post-reset LW 0x20", rd, 32'h01020304);
        check("post-reset LW err", 32'(er), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

endmodule
